// File: rtl/gray_binarize_pkg.sv
// Shared types and constants for the gray_binarize video stage and
// the stream helpers built around it.
package gray_binarize_pkg;

  localparam int DATA_W = 32;
  localparam int PIX_W  = 10;

  localparam logic [29:0] WHITE_PIX = 30'h3FFF_FFFF;
  localparam logic [29:0] BLACK_PIX = 30'h0;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI4-Stream buffer. The upstream ready is a flop that depends
// only on occupancy, so no combinational path runs from out_ready to in_ready.
module axis_skid_buf
  import gray_binarize_pkg::*;
(
  input  logic       axis_aclk,
  input  logic       axis_aresetn,
  input  axis_beat_t in_beat,
  input  logic       in_valid,
  output logic       in_ready,
  output axis_beat_t out_beat,
  output logic       out_valid,
  input  logic       out_ready
);

  axis_beat_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       push;
  logic       pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_beat  = mem[rd_ptr];

  assign count_nxt = count + 2'(push) - 2'(pop);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      // NOTE: the storage is reset on purpose so the output word reads zero
      // out of reset; data-only RAMs elsewhere normally skip this.
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values; blocking ones here would create order-dependent races.
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/gray_binarize.sv
// Thresholds a 10-bit gray pixel to black/white, with config shadowed at
// start-of-frame and per-frame white/line statistics.
module gray_binarize #(
  parameter int DATA_W = gray_binarize_pkg::DATA_W,
  parameter int PIX_W  = gray_binarize_pkg::PIX_W,
  parameter int CNT_W  = 32
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              cfg_enable,
  input  logic [PIX_W-1:0]  cfg_threshold,
  input  logic              cfg_invert,
  output logic [CNT_W-1:0]  stat_white_cnt,
  output logic [CNT_W-1:0]  stat_line_cnt,
  output logic [CNT_W-1:0]  stat_drop_cnt,
  output logic              stat_frame_pulse
);

  import gray_binarize_pkg::*;

  state_t            state_q;
  state_t            state_d;
  logic              keep;
  logic              accept;

  logic              sh_en_q;
  logic              sh_inv_q;
  logic [PIX_W-1:0]  sh_thr_q;

  logic              en_eff;
  logic              inv_eff;
  logic [PIX_W-1:0]  thr_eff;
  logic [PIX_W-1:0]  gray;
  logic              white;

  logic [CNT_W-1:0]  white_acc_q;
  logic [CNT_W-1:0]  line_acc_q;
  logic [CNT_W-1:0]  white_inc;
  logic [CNT_W-1:0]  line_inc;

  axis_beat_t        in_beat;
  axis_beat_t        out_beat;

  assign accept = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state_q <= WAIT_SOF;
    else               state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    state_d = state_q;
    keep    = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        keep = s_axis_tuser;
        if (accept && s_axis_tuser) state_d = ACTIVE;
      end
      ACTIVE:   keep = 1'b1;
      default:  state_d = WAIT_SOF;
    endcase
  end

  // The SOF beat is processed with the config it latches, not the old shadow.
  assign en_eff  = s_axis_tuser ? cfg_enable    : sh_en_q;
  assign inv_eff = s_axis_tuser ? cfg_invert    : sh_inv_q;
  assign thr_eff = s_axis_tuser ? cfg_threshold : sh_thr_q;

  assign gray  = s_axis_tdata[PIX_W-1:0];
  assign white = (gray >= thr_eff) ^ inv_eff;

  always_comb begin
    in_beat.tdata = s_axis_tdata;
    in_beat.tuser = s_axis_tuser;
    in_beat.tlast = s_axis_tlast;
    if (en_eff) in_beat.tdata = {2'b00, (white ? WHITE_PIX : BLACK_PIX)};
  end

  axis_skid_buf u_skid (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .in_beat      (in_beat),
    .in_valid     (s_axis_tvalid & keep),
    .in_ready     (s_axis_tready),
    .out_beat     (out_beat),
    .out_valid    (m_axis_tvalid),
    .out_ready    (m_axis_tready)
  );

  assign m_axis_tdata = out_beat.tdata;
  assign m_axis_tuser = out_beat.tuser;
  assign m_axis_tlast = out_beat.tlast;

  assign white_inc = CNT_W'(en_eff & white);
  assign line_inc  = CNT_W'(s_axis_tlast);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      sh_en_q          <= 1'b0;
      sh_inv_q         <= 1'b0;
      sh_thr_q         <= '0;
      white_acc_q      <= '0;
      line_acc_q       <= '0;
      stat_white_cnt   <= '0;
      stat_line_cnt    <= '0;
      stat_drop_cnt    <= '0;
      stat_frame_pulse <= 1'b0;
    end else begin
      stat_frame_pulse <= 1'b0;
      if (accept) begin
        if (s_axis_tuser) begin
          sh_en_q     <= cfg_enable;
          sh_inv_q    <= cfg_invert;
          sh_thr_q    <= cfg_threshold;
          white_acc_q <= white_inc;
          line_acc_q  <= line_inc;
          // The first SOF after reset closes no frame, so publishes nothing.
          if (state_q == ACTIVE) begin
            stat_white_cnt   <= white_acc_q;
            stat_line_cnt    <= line_acc_q;
            stat_frame_pulse <= 1'b1;
          end
        end else if (state_q == ACTIVE) begin
          white_acc_q <= white_acc_q + white_inc;
          line_acc_q  <= line_acc_q + line_inc;
        end else if (stat_drop_cnt != '1) begin
          stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_binarize.sv
// Scoreboard bench for gray_binarize: input monitor feeds a behavioural
// frame model into an expected queue, output monitor pops and compares.
module tb_gray_binarize;

  logic        axis_aclk = 1'b0;
  logic        axis_aresetn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        cfg_enable = 1'b0;
  logic [9:0]  cfg_threshold = '0;
  logic        cfg_invert = 1'b0;
  logic [31:0] stat_white_cnt;
  logic [31:0] stat_line_cnt;
  logic [31:0] stat_drop_cnt;
  logic        stat_frame_pulse;

  gray_binarize dut (
    .axis_aclk        (axis_aclk),
    .axis_aresetn     (axis_aresetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tlast     (m_axis_tlast),
    .cfg_enable       (cfg_enable),
    .cfg_threshold    (cfg_threshold),
    .cfg_invert       (cfg_invert),
    .stat_white_cnt   (stat_white_cnt),
    .stat_line_cnt    (stat_line_cnt),
    .stat_drop_cnt    (stat_drop_cnt),
    .stat_frame_pulse (stat_frame_pulse)
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model state: frame membership, shadow config, accumulators.
  logic [33:0] exp_q [$];
  bit          in_frame = 0;
  bit          sh_en, sh_inv;
  int unsigned sh_thr;
  int unsigned white_acc, line_acc;
  int unsigned exp_white, exp_line, exp_drop;
  int          exp_pulses;
  int          n_push, n_pop, n_out, n_pulse;
  logic [31:0] last_out_data;
  logic        last_out_user;
  int          ready_mode = 0;

  always @(negedge axis_aclk) begin : in_mon
    if (!axis_aresetn) begin
      exp_q.delete();
      in_frame  = 0;
      white_acc = 0;
      line_acc  = 0;
      exp_white = 0;
      exp_line  = 0;
      exp_drop  = 0;
      n_push    = 0;
    end else if (s_axis_tvalid && s_axis_tready) begin
      if (!in_frame && !s_axis_tuser) begin
        if (exp_drop != 32'hFFFF_FFFF) exp_drop++;
      end else begin
        bit          w;
        logic [31:0] od;
        if (s_axis_tuser) begin
          if (in_frame) begin
            exp_white = white_acc;
            exp_line  = line_acc;
            exp_pulses++;
          end
          in_frame  = 1;
          sh_en     = cfg_enable;
          sh_inv    = cfg_invert;
          sh_thr    = cfg_threshold;
          white_acc = 0;
          line_acc  = 0;
        end
        w  = ((s_axis_tdata % 1024) >= sh_thr) != sh_inv;
        od = sh_en ? (w ? 32'h3FFF_FFFF : 32'h0) : s_axis_tdata;
        if (sh_en && w) white_acc++;
        if (s_axis_tlast) line_acc++;
        exp_q.push_back({od, s_axis_tuser, s_axis_tlast});
        n_push++;
      end
    end
  end

  always @(negedge axis_aclk) begin : out_mon
    if (!axis_aresetn) begin
      n_pop = 0;
    end else begin
      if (stat_frame_pulse) n_pulse++;
      if (m_axis_tvalid && m_axis_tready) begin
        n_pop++;
        n_out++;
        last_out_data = m_axis_tdata;
        last_out_user = m_axis_tuser;
        if (exp_q.size() == 0)
          check("unexpected_output", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 34'h0_DEAD_BEEF);
        else
          check("out_beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, exp_q.pop_front());
      end
    end
  end

  // Ready must track occupancy of the two-entry buffer exactly.
  bit armed = 0;
  always @(posedge axis_aclk) begin : occ_mon
    #2;
    if (!axis_aresetn) armed = 0;
    else begin
      if (s_axis_tready) armed = 1;
      if (armed) check("s_ready_vs_occ", s_axis_tready, (n_push - n_pop) < 2);
    end
  end

  always @(posedge axis_aclk) begin : ready_drv
    #1;
    case (ready_mode)
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      2:       m_axis_tready = 1'b0;
      default: m_axis_tready = 1'b1;
    endcase
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    int waited = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    forever begin
      @(negedge axis_aclk);
      if (s_axis_tready) break;
      waited++;
      if (waited > 1000) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int px, input bit rnd, input int flip_at);
    for (int li = 0; li < lines; li++) begin
      for (int pi = 0; pi < px; pi++) begin
        logic [9:0]  g;
        logic [31:0] d;
        if (li * px + pi == flip_at) cfg_enable = 1'b1;
        g = (pi % 2 == 0) ? 10'h0FF : 10'h100;
        d = rnd ? $urandom : {2'b00, g, g, g};
        send_beat(d, (li == 0 && pi == 0), (pi == px - 1));
      end
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge axis_aclk);
      waited++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge axis_aclk);
    #1;
  endtask

  task automatic check_stats(input string tag, input int w, input int l, input int pulses);
    check({tag, "_white"}, stat_white_cnt, w);
    check({tag, "_line"}, stat_line_cnt, l);
    check({tag, "_pulses"}, n_pulse, pulses);
    check({tag, "_white_model"}, stat_white_cnt, exp_white);
    check({tag, "_line_model"}, stat_line_cnt, exp_line);
  endtask

  initial begin
    int p0, o0;
    repeat (3) @(posedge axis_aclk);
    #1;
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_data", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 0);
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_stats", {stat_white_cnt, stat_line_cnt}, 0);
    check("rst_drop", stat_drop_cnt, 0);
    check("rst_pulse", stat_frame_pulse, 0);
    axis_aresetn = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #1;
    check("s_ready_after_rst", s_axis_tready, 1);

    // Pre-SOF beats are dropped, then the SOF beat uses current config.
    cfg_enable = 1'b1; cfg_threshold = 10'h100; cfg_invert = 1'b0;
    for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 1'b0);
    send_beat(32'h0000_0200, 1'b1, 1'b0);
    drain();
    check("drop_cnt", stat_drop_cnt, 5);
    check("drop_model", stat_drop_cnt, exp_drop);
    check("first_out_data", last_out_data, 32'h3FFF_FFFF);
    check("first_out_user", last_out_user, 1);
    check("no_pulse_first_sof", n_pulse, 0);
    check("out_count_t1", n_out, 1);

    // 4x8 alternating frame, then same frame inverted.
    send_frame(4, 8, 0, -1);
    drain();
    check_stats("t1_close", 1, 0, 1);
    cfg_invert = 1'b1;
    p0 = n_pulse;
    send_frame(4, 8, 0, -1);
    drain();
    check_stats("alt_frame", 16, 4, p0 + 1);

    // Pass-through with an enable change mid-frame.
    cfg_enable = 1'b0; cfg_invert = 1'b0;
    send_frame(2, 8, 1, 5);
    drain();
    check_stats("inv_frame", 16, 4, p0 + 2);

    // Random data, random thresholds, random downstream ready.
    cfg_threshold = 10'($urandom);
    cfg_invert    = 1'($urandom);
    ready_mode    = 1;
    for (int i = 0; i < 100; i++)
      send_beat($urandom, (i == 0), (i == 99) || ($urandom_range(0, 7) == 0));
    drain();
    check_stats("bypass_frame", 0, 2, p0 + 3);
    ready_mode = 0;
    send_beat($urandom, 1'b1, 1'b0);
    drain();
    check("rand_pulses", n_pulse, p0 + 4);
    check("rand_white_model", stat_white_cnt, exp_white);
    check("rand_line_model", stat_line_cnt, exp_line);

    // Reset mid-frame with output stalled.
    ready_mode = 2;
    repeat (2) @(posedge axis_aclk);
    #1;
    send_beat($urandom, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0);
    axis_aresetn = 1'b0;
    #1;
    check("midrst_m_valid", m_axis_tvalid, 0);
    check("midrst_stats", {stat_white_cnt, stat_line_cnt, stat_drop_cnt}, 0);
    ready_mode = 0;
    repeat (3) @(posedge axis_aclk);
    #1;
    axis_aresetn = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #1;
    o0 = n_out;
    for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, 1'b1);
    repeat (5) @(posedge axis_aclk);
    #1;
    check("post_rst_drop", stat_drop_cnt, 3);
    check("post_rst_no_out", n_out, o0);
    send_beat(32'h0000_03FF, 1'b1, 1'b0);
    drain();
    check("post_rst_sof_out", n_out, o0 + 1);
    check("post_rst_stats", {stat_white_cnt, stat_line_cnt}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
